// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and its consumer.
// The master drives the held byte and status flags; the slave drives ready.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;

    modport master (
        output rx_data,
        output rx_frame_err,
        output rx_valid,
        output rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_frame_err,
        input  rx_valid,
        input  rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a programmable bit period and a one-entry holding register.
// A held-low line after a framing error is parked in a break state until it returns high.
module uart_rx #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             rxd,
    input  logic [DIV_W-1:0] clkdiv,
    output logic             busy,
    uart_rx_if.master        rx
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StBreak = 3'd4;

    logic [1:0]       sync_q;
    logic             rxs;
    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             ferr_q, ferr_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             sample;
    logic             frame_done;
    logic             frame_ferr;
    logic             accept;

    assign rxs    = sync_q[1];
    assign sample = (cnt_q == '0);
    assign accept = valid_q && rx.rx_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        frame_done = 1'b0;
        frame_ferr = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = sample ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
        end

        case (state_q)
            StIdle: begin
                if (!rxs) begin
                    // Half-period preload puts every later sample mid-bit.
                    div_d   = clkdiv;
                    cnt_d   = (clkdiv >> 1) - DIV_W'(1);
                    state_d = StStart;
                end
            end
            StStart: begin
                if (sample) begin
                    if (!rxs) begin
                        state_d = StData;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (sample) begin
                    shreg_d = {rxs, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (sample) begin
                    frame_done = 1'b1;
                    frame_ferr = !rxs;
                    state_d    = rxs ? StIdle : StBreak;
                end
            end
            StBreak: begin
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        ferr_d  = ferr_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (frame_done) begin
            if (!valid_q || accept) begin
                data_d  = shreg_q;
                ferr_d  = frame_ferr;
                valid_d = 1'b1;
                if (accept) begin
                    ovr_d = 1'b0;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_frame_err = ferr_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_overrun   = ovr_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-built corner sequences and random traffic
// checked every cycle against a transaction-level model of the holding register.
module tb_uart_rx;

    logic        clk;
    logic        reset_in;
    logic        rxd;
    logic [15:0] clkdiv;
    logic        busy;

    uart_rx_if rx_bus ();

    uart_rx #(
        .DIV_W (16)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .rxd      (rxd),
        .clkdiv   (clkdiv),
        .busy     (busy),
        .rx       (rx_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;
    bit rand_rdy = 1'b0;

    // Expected frame completions, keyed by the clock edge on which the stop bit is sampled.
    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         ferr;
    } exp_t;
    exp_t exp_q[$];

    logic       m_valid, m_ferr, m_ovr;
    logic [7:0] m_data;

    logic       obs_valid, obs_ferr, obs_busy;
    logic [7:0] obs_data;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Holding-register model: byte lands on its frame-complete edge, or is dropped as overrun.
    always @(posedge clk) begin
        logic rdy, acc, done;
        exp_t f;
        cyc++;
        rdy  = rx_bus.rx_ready;
        done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (!reset_in) begin
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            m_data  = 8'h00;
            exp_q.delete();
        end else begin
            acc = m_valid && rdy;
            if (done) begin
                f = exp_q.pop_front();
                if (!m_valid || acc) begin
                    m_data  = f.data;
                    m_ferr  = f.ferr;
                    m_valid = 1'b1;
                    if (acc) m_ovr = 1'b0;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (acc) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
        end
        #1;
        if (chk_on) begin
            chk("model_valid", rx_bus.rx_valid, m_valid);
            chk("model_data", rx_bus.rx_data, m_data);
            chk("model_ferr", rx_bus.rx_frame_err, m_ferr);
            chk("model_overrun", rx_bus.rx_overrun, m_ovr);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) rx_bus.rx_ready = ($urandom_range(0, 3) == 0);
        end
    end

    // Drives one 8N1 frame at div clocks per bit; start bit is driven on the current negedge.
    // Two sync flops plus detection put the start at edge n+3, then half a bit plus nine bits.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int div,
                              input bit pulse);
        logic [9:0] bits;
        int         done;
        exp_t       e;
        clkdiv = div[15:0];
        done   = cyc + 3 + div / 2 + 9 * div;
        e.cyc  = done;
        e.data = d;
        e.ferr = !stop;
        exp_q.push_back(e);
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd = bits[b];
            for (int k = 0; k < div; k++) begin
                if (cyc == done) begin
                    obs_valid = rx_bus.rx_valid;
                    obs_data  = rx_bus.rx_data;
                    obs_ferr  = rx_bus.rx_frame_err;
                    obs_busy  = busy;
                end
                if (pulse) rx_bus.rx_ready = (cyc == done - 1);
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         div;
        int         gap;
        logic [7:0] exp_data;
        bit         exp_ferr;
        bit         exp_busy;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] pat;
    int         gap;
    logic [7:0] rd;
    int         rdiv;
    bit         rstop;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 16, 4, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 8, 0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 16, 10, 8'hFF, 1'b1, 1'b1};
        vecs[3] = '{8'h5A, 1'b1, 37, 3, 8'h5A, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 9, 5, 8'h81, 1'b1, 1'b1};

        reset_in         = 1'b0;
        rxd              = 1'b1;
        clkdiv           = 16'd16;
        rx_bus.rx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", rx_bus.rx_valid, 1'b0);
        chk("reset_data", rx_bus.rx_data, 8'h00);
        chk("reset_ferr", rx_bus.rx_frame_err, 1'b0);
        chk("reset_overrun", rx_bus.rx_overrun, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk_on   = 1'b1;
        reset_in = 1'b1;
        idle(5);

        // Directed frame table, consumer always ready.
        rx_bus.rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].div, 1'b0);
            chk("tbl_valid", obs_valid, 1'b1);
            chk("tbl_data", obs_data, vecs[i].exp_data);
            chk("tbl_ferr", obs_ferr, vecs[i].exp_ferr);
            chk("tbl_busy", obs_busy, vecs[i].exp_busy);
            idle(vecs[i].gap);
        end
        idle(10);

        // Back-to-back with stalled consumer.
        rx_bus.rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1, 16, 1'b0);
        send_frame(8'h81, 1'b1, 16, 1'b0);
        idle(5);
        chk("stall_valid", rx_bus.rx_valid, 1'b1);
        chk("stall_data", rx_bus.rx_data, 8'h3C);
        chk("stall_overrun", rx_bus.rx_overrun, 1'b1);
        rx_bus.rx_ready = 1'b1;
        @(negedge clk);
        rx_bus.rx_ready = 1'b0;
        chk("accept_valid", rx_bus.rx_valid, 1'b0);
        chk("accept_overrun", rx_bus.rx_overrun, 1'b0);
        chk("accept_data_hold", rx_bus.rx_data, 8'h3C);
        idle(5);

        // Accept on the very edge a new frame completes.
        send_frame(8'h11, 1'b1, 16, 1'b0);
        idle(5);
        send_frame(8'h55, 1'b1, 16, 1'b1);
        idle(2);
        chk("simul_valid", rx_bus.rx_valid, 1'b1);
        chk("simul_data", rx_bus.rx_data, 8'h55);
        chk("simul_overrun", rx_bus.rx_overrun, 1'b0);

        // Reset during data bit 4 with a byte still held.
        clkdiv = 16'd16;
        pat    = 8'hB4;
        rxd    = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = pat[i];
            repeat (16) @(negedge clk);
        end
        rxd = pat[4];
        repeat (8) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        reset_in = 1'b0;
        rxd      = 1'b1;
        @(negedge clk);
        chk("midrst_valid", rx_bus.rx_valid, 1'b0);
        chk("midrst_data", rx_bus.rx_data, 8'h00);
        chk("midrst_ferr", rx_bus.rx_frame_err, 1'b0);
        chk("midrst_overrun", rx_bus.rx_overrun, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        reset_in = 1'b1;
        idle(20);
        rx_bus.rx_ready = 1'b1;
        send_frame(8'hC3, 1'b1, 16, 1'b0);
        chk("post_rst_valid", obs_valid, 1'b1);
        chk("post_rst_data", obs_data, 8'hC3);
        idle(10);

        // Short low glitch is rejected at the start-bit sample.
        clkdiv = 16'd16;
        rxd    = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        chk("glitch_busy_rise", busy, 1'b1);
        repeat (20) @(negedge clk);
        chk("glitch_busy_fall", busy, 1'b0);
        chk("glitch_no_valid", rx_bus.rx_valid, 1'b0);

        // Framing error followed by a line held low for 40 bit times.
        send_frame(8'hFF, 1'b0, 16, 1'b0);
        chk("ferr_valid", obs_valid, 1'b1);
        chk("ferr_data", obs_data, 8'hFF);
        chk("ferr_flag", obs_ferr, 1'b1);
        repeat (40 * 16) @(negedge clk);
        chk("break_busy", busy, 1'b1);
        chk("break_no_valid", rx_bus.rx_valid, 1'b0);
        idle(6);
        chk("break_exit_busy", busy, 1'b0);
        idle(10);

        // Divisor change mid-frame only affects the next frame.
        fork
            send_frame(8'h69, 1'b1, 16, 1'b0);
            begin
                repeat (70) @(negedge clk);
                clkdiv = 16'd8;
            end
        join
        chk("divchg_data0", obs_data, 8'h69);
        chk("divchg_valid0", obs_valid, 1'b1);
        idle(3);
        send_frame(8'h96, 1'b1, 8, 1'b0);
        chk("divchg_data1", obs_data, 8'h96);
        chk("divchg_valid1", obs_valid, 1'b1);
        idle(10);

        // Random traffic with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rd    = 8'($urandom);
            rdiv  = int'($urandom_range(8, 40));
            rstop = ($urandom_range(0, 9) != 0);
            send_frame(rd, rstop, rdiv, 1'b0);
            gap = rstop ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
            idle(gap);
        end
        rand_rdy        = 1'b0;
        rx_bus.rx_ready = 1'b1;
        idle(20);
        chk("all_frames_seen", exp_q.size(), 0);
        chk("final_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish by 2000000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the board UART_RXD pin: 8 data bits, no parity, 1 stop bit (8N1), LSB first.
- Runs at a programmable bit period and presents each received byte through a one-entry holding register with a valid/ready handshake.
- Sits between the toplevel UART_RXD pad and the SoC peripheral bus logic. It is the receiving end of the existing UART transmit path.

Parameters:
- DIV_W, 16, width of the clkdiv input and the internal bit-period counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_in  input  1  synchronous, active-low reset.
- rxd  input  1  asynchronous serial input from the pad; idle high.
- clkdiv  input  DIV_W  clocks per bit (for example 434 for 115200 baud at 50 MHz); legal range 4..2^DIV_W-1.
- rx_data  output  8  received byte.
- rx_frame_err  output  1  stop bit of rx_data was sampled low.
- rx_valid  output  1  holding register is occupied.
- rx_ready  input  1  consumer accepts the byte when rx_valid and rx_ready are both high on a clk edge.
- rx_overrun  output  1  sticky flag: a completed frame was dropped because the holding register was full.
- busy  output  1  a frame is in progress (state other than IDLE).

Behaviour:
- Reset (reset_in=0 at a clk edge):
  - State goes to IDLE; both synchronizer flops go to 1.
  - rx_data=0, rx_frame_err=0, rx_valid=0, rx_overrun=0, busy=0.
  - Any partial frame or held byte is discarded.
- Synchronizer: rxd passes through 2 flops (rxs). All decisions use rxs, so pin-to-decision latency is 2 clocks.
- Bit counter:
  - cnt decrements by 1 each clk.
  - A sample is taken on the cycle cnt==0, and cnt reloads to div_l-1 on that same cycle, giving exactly div_l clocks between samples.
  - div_l is clkdiv latched at start detection, so clkdiv changes mid-frame have no effect until the next frame.
- States:
  - IDLE:
    - When rxs==0: latch div_l=clkdiv, load cnt=(clkdiv>>1)-1, go to START. busy=1 from the next cycle.
  - START:
    - At sample, rxs==0: go to DATA with bit index=0.
    - At sample, rxs==1: false start (glitch); go to IDLE with no output and no flags.
  - DATA:
    - At each sample, shift rxs into shreg[7] and shift right.
    - After the 8th sample go to STOP.
  - STOP (one sample):
    - Frame complete. Data=shreg; ferr = (rxs==0).
    - If ferr=0, go to IDLE. If ferr=1, go to BREAK.
  - BREAK:
    - Wait until rxs==1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- Holding register, evaluated on the frame-complete cycle:
  - If rx_valid==0, or rx_valid&&rx_ready in the same cycle: load rx_data and rx_frame_err, and set rx_valid=1.
  - Otherwise: the new frame is discarded, rx_overrun is set to 1, and the held byte and flag are unchanged.
- Accept: rx_valid&&rx_ready with no frame completing clears rx_valid. rx_data and rx_frame_err hold their last value.
- rx_overrun:
  - Set as described above.
  - Cleared on any accept cycle, unless a new overrun occurs in the same cycle (impossible by construction, because an accept frees the slot).
- rx_valid rises 1 clk after the stop-bit sample.
- Frame-complete to rx_valid latency is 1 clk. Start edge at the pin to rx_valid is roughly 2 + 9.5*div_l clocks.
- clkdiv<4 is unsupported; behaviour is undefined but must not lock up after reset.

Test Plan:
- Basic receive: clkdiv=16, rx_ready=1, send 0xA5 with a good stop bit -> rx_valid pulses for 1 clk with rx_data=0xA5 and rx_frame_err=0, roughly 154 clks after the start edge. busy falls after the stop sample.
- Back-to-back with stall: clkdiv=16, rx_ready=0, send 0x3C then 0x81 with no idle gap -> 0x3C held with rx_valid=1, 0x81 dropped, rx_overrun=1. Raising rx_ready for 1 clk accepts 0x3C and clears rx_overrun and rx_valid.
- Simultaneous accept: assert rx_ready on exactly the frame-complete cycle of 0x55 while 0x11 is held -> 0x11 consumed, rx_data=0x55, rx_valid stays 1, rx_overrun stays 0.
- Glitch and framing: a 4-clk low pulse at clkdiv=16 produces no output and busy returns to 0. A frame 0xFF with the stop bit low gives rx_frame_err=1 and rx_data=0xFF. Holding the line low for 40 bit times afterwards produces no further frames until rxd returns high.
- Divisor change: change clkdiv from 16 to 8 mid-frame -> the current byte 0x69 is received correctly at 16. The next frame is received correctly at 8.
- Reset mid-frame: drive reset_in=0 during data bit 4 -> all outputs 0 on the next clk. After release, a fresh 0xC3 frame is received correctly.
